// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states and datapath select codes.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate format select, purely from the opcode and independent of FSM state.
module imm_src_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [2:0] imm_src_o
);

    always_comb begin
        unique case (op_i)
            OP_STORE:         imm_src_o = IMM_S;
            OP_BRANCH:        imm_src_o = IMM_B;
            OP_JAL:           imm_src_o = IMM_J;
            OP_LUI, OP_AUIPC: imm_src_o = IMM_U;
            default:          imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control: state register plus Moore/Mealy output decode.
module multicycle_control_fsm
    import riscv_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_op_o,
    output logic [2:0] imm_src_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    state_t state_q, state_d;
    logic   ready;
    logic   illegal_op;
    logic   unused_funct3;

    assign ready         = (MEM_WAIT_EN != 0) ? mem_ready_i : 1'b1;
    assign unused_funct3 = ^funct3_i[2:1];
    assign state_o       = state_q;

    imm_src_decoder u_imm_src (
        .op_i     (op_i),
        .imm_src_o(imm_src_o)
    );

    always_comb begin
        state_d    = S_FETCH;
        illegal_op = 1'b0;
        unique case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           illegal_op = 1'b1;
                endcase
            end
            S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Output decode; reset gates everything so an in-flight access is dropped at once.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        result_src_o = RES_ALUOUT;
        alu_op_o     = ALUOP_ADD;
        illegal_o    = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req_o    = 1'b1;
                    alu_src_b_o  = SRCB_FOUR;
                    result_src_o = RES_ALU;
                    ir_write_o   = ready;
                    pc_write_o   = ready;
                end
                S_DECODE: begin
                    alu_src_a_o = SRCA_OLDPC;
                    alu_src_b_o = SRCB_IMM;
                    illegal_o   = illegal_op;
                end
                S_MEMADR: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                end
                S_MEMWB: begin
                    result_src_o = RES_MEM;
                    reg_write_o  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req_o   = 1'b1;
                    mem_write_o = 1'b1;
                    adr_src_o   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_op_o    = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_IMM;
                    alu_op_o    = ALUOP_FUNCT;
                end
                S_ALUWB:  reg_write_o = 1'b1;
                S_BRANCH: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_op_o    = ALUOP_SUB;
                    pc_write_o  = zero_i ^ funct3_i[0];
                end
                S_JALR: begin
                    alu_src_a_o = SRCA_RS1;
                    alu_src_b_o = SRCB_IMM;
                end
                S_JAL: begin
                    alu_src_a_o = SRCA_OLDPC;
                    alu_src_b_o = SRCB_FOUR;
                    pc_write_o  = 1'b1;
                end
                S_LUI: begin
                    alu_src_a_o = SRCA_ZERO;
                    alu_src_b_o = SRCB_IMM;
                    alu_op_o    = ALUOP_LUI;
                end
                S_AUIPC: begin
                    alu_src_a_o = SRCA_OLDPC;
                    alu_src_b_o = SRCB_IMM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed and randomized bench for multicycle_control_fsm against a per-instruction path model.
module tb_multicycle_control_fsm;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o, alu_op_o;
    logic [2:0] imm_src_o;
    logic       illegal_o;
    logic [3:0] state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    multicycle_control_fsm #(.MEM_WAIT_EN(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
        .mem_write_o(mem_write_o), .adr_src_o(adr_src_o), .ir_write_o(ir_write_o),
        .pc_write_o(pc_write_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .result_src_o(result_src_o), .alu_op_o(alu_op_o),
        .imm_src_o(imm_src_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    // Per-state Moore row: mem_req, mem_write, adr_src, reg_write, A, B, result_src, alu_op
    typedef struct packed {
        logic       mreq, mwr, adr, rw;
        logic [1:0] a, b, res, aop;
    } row_t;
    row_t tbl [16];
    int   path[$];

    function automatic row_t mk(input logic mreq, mwr, adr, rw,
                                input logic [1:0] a, b, res, aop);
        row_t r;
        r.mreq = mreq; r.mwr = mwr; r.adr = adr; r.rw = rw;
        r.a = a; r.b = b; r.res = res; r.aop = aop;
        return r;
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    task automatic build_path(input logic [6:0] op);
        case (op)
            7'b0000011: path = '{0, 1, 2, 3, 4};
            7'b0100011: path = '{0, 1, 2, 5};
            7'b0110011: path = '{0, 1, 6, 8};
            7'b0010011: path = '{0, 1, 7, 8};
            7'b1100011: path = '{0, 1, 9};
            7'b1101111: path = '{0, 1, 10, 8};
            7'b1100111: path = '{0, 1, 11, 10, 8};
            7'b0110111: path = '{0, 1, 12, 8};
            7'b0010111: path = '{0, 1, 13, 8};
            default:    path = '{0, 1};
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input int s, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input logic rdy);
        row_t r;
        logic legal;
        r     = tbl[s];
        legal = !(path.size() == 2);
        chk("state", 32'(state_o), 32'(s));
        chk("mem_req", 32'(mem_req_o), 32'(r.mreq));
        chk("mem_write", 32'(mem_write_o), 32'(r.mwr));
        chk("adr_src", 32'(adr_src_o), 32'(r.adr));
        chk("reg_write", 32'(reg_write_o), 32'(r.rw));
        chk("alu_src_a", 32'(alu_src_a_o), 32'(r.a));
        chk("alu_src_b", 32'(alu_src_b_o), 32'(r.b));
        chk("result_src", 32'(result_src_o), 32'(r.res));
        chk("alu_op", 32'(alu_op_o), 32'(r.aop));
        chk("ir_write", 32'(ir_write_o), 32'(s == 0 && rdy));
        chk("pc_write", 32'(pc_write_o),
            32'((s == 0 && rdy) || (s == 9 && (z ^ f3[0])) || s == 10));
        chk("illegal", 32'(illegal_o), 32'(s == 1 && !legal));
        chk("imm_src", 32'(imm_src_o), 32'(exp_imm(op)));
    endtask

    // mode 0: random ready/zero; mode 1: ready low for low_cnt cycles of memory waits, zero fixed.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int mode,
                             input int low_cnt, input logic zfix);
        int idx = 0, waits = 0, cycles = 0, low_left = low_cnt, s;
        logic rdy, z;
        build_path(op);
        while (idx < path.size() && cycles < 24) begin
            @(negedge clk_i);
            s = path[idx];
            if (mode == 0) begin
                rdy = (waits >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
                z   = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
                if ((s == 0 || s == 3 || s == 5) && low_left > 0) begin
                    rdy = 1'b0;
                    low_left--;
                end
                z = zfix;
            end
            op_i = op; funct3_i = f3; zero_i = z; mem_ready_i = rdy;
            #1;
            check_all(s, op, f3, z, rdy);
            if ((s == 0 || s == 3 || s == 5) && !rdy) waits++;
            else idx++;
            cycles++;
        end
        if (idx < path.size()) chk("cycle_budget", 32'(idx), 32'(path.size()));
    endtask

    logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[0]  = mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00);
        tbl[1]  = mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        tbl[2]  = mk(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00);
        tbl[3]  = mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[4]  = mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00);
        tbl[5]  = mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[6]  = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10);
        tbl[7]  = mk(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10);
        tbl[8]  = mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[9]  = mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01);
        tbl[10] = mk(0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00);
        tbl[11] = mk(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00);
        tbl[12] = mk(0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b11);
        tbl[13] = mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);

        rst_i = 1'b1; op_i = 7'b0110011; funct3_i = 3'b000; zero_i = 1'b0; mem_ready_i = 1'b1;
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_mem_req", 32'(mem_req_o), 32'd0);
        chk("reset_ir_write", 32'(ir_write_o), 32'd0);
        chk("reset_pc_write", 32'(pc_write_o), 32'd0);
        chk("reset_src_b", 32'(alu_src_b_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset asserted while a store waits in MEMWRITE
        op_i = 7'b0100011; mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        #1;
        chk("pre_rst_state", 32'(state_o), 32'd5);
        chk("pre_rst_mem_write", 32'(mem_write_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("rst_mid_state", 32'(state_o), 32'd0);
        chk("rst_mid_mem_write", 32'(mem_write_o), 32'd0);
        chk("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_mem_req", 32'(mem_req_o), 32'd1);

        run_instr(7'b0110011, 3'b000, 1, 0, 1'b0);
        run_instr(7'b0000011, 3'b010, 1, 3, 1'b0);
        run_instr(7'b1100011, 3'b000, 1, 0, 1'b1);
        run_instr(7'b1100011, 3'b001, 1, 0, 1'b1);
        run_instr(7'b1100011, 3'b001, 1, 0, 1'b0);
        run_instr(7'b1100111, 3'b000, 1, 0, 1'b0);
        run_instr(7'b0110111, 3'b000, 1, 0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1, 0, 1'b0);
        run_instr(7'b0100011, 3'b010, 1, 2, 1'b0);

        for (int n = 0; n < 80; n++)
            run_instr(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
